// File: rtl/ir_sequencer.sv
// IR proximity sequencer: pulses the emitter, converts left/right channels,
// and publishes a matched reading pair with hysteretic opening flags.
module ir_sequencer #(
  parameter int unsigned PERIOD    = 1024,
  parameter int unsigned SETTLE    = 64,
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [2:0]  LFT_CHNL  = 3'd0,
  parameter logic [2:0]  RGHT_CHNL = 3'd4,
  parameter logic [11:0] OPN_THRES = 12'h200,
  parameter logic [11:0] HYST      = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_en,
  output logic [11:0] lft_IR,
  output logic [11:0] rght_IR,
  output logic        lft_opn,
  output logic        rght_opn,
  output logic        en_fusion,
  output logic        IR_vld,
  output logic        fault
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [11:0]   CLR_THRES = OPN_THRES + HYST;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CNV_L,
    S_WAIT_L,
    S_CNV_R,
    S_WAIT_R,
    S_UPDATE
  } state_t;

  state_t        state;
  logic [PW-1:0] per_cnt;
  logic [SW-1:0] set_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [11:0]   lft_raw;
  logic [11:0]   rght_raw;

  // Below the threshold sets, above threshold+hyst clears, between holds.
  function automatic logic opn_next(input logic [11:0] rd,
                                    input logic        cur);
    if (rd < OPN_THRES)
      return 1'b1;
    else if (rd > CLR_THRES)
      return 1'b0;
    else
      return cur;
  endfunction

  // Free-running measurement period, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable)
      per_cnt <= '0;
    else if (per_cnt == PER_LAST)
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + 1'b1;
  end

  // Measurement sequence with registered handshake and publish outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      set_cnt   <= '0;
      tmo_cnt   <= '0;
      strt_cnv  <= 1'b0;
      chnnl     <= '0;
      IR_en     <= 1'b0;
      lft_raw   <= '0;
      rght_raw  <= '0;
      lft_IR    <= '0;
      rght_IR   <= '0;
      lft_opn   <= 1'b0;
      rght_opn  <= 1'b0;
      en_fusion <= 1'b0;
      IR_vld    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      IR_vld   <= 1'b0;
      strt_cnv <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!enable)
            en_fusion <= 1'b0;
          if (enable && per_cnt == '0) begin
            state   <= S_SETTLE;
            IR_en   <= 1'b1;
            set_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (set_cnt == SET_LAST) begin
            state    <= S_CNV_L;
            strt_cnv <= 1'b1;
            chnnl    <= LFT_CHNL;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        S_CNV_L: begin
          state   <= S_WAIT_L;
          tmo_cnt <= '0;
        end
        S_WAIT_L: begin
          if (cnv_cmplt) begin
            lft_raw  <= res;
            state    <= S_CNV_R;
            strt_cnv <= 1'b1;
            chnnl    <= RGHT_CHNL;
          end else if (tmo_cnt == TMO_LAST) begin
            fault     <= 1'b1;
            en_fusion <= 1'b0;
            IR_en     <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CNV_R: begin
          state   <= S_WAIT_R;
          tmo_cnt <= '0;
        end
        S_WAIT_R: begin
          if (cnv_cmplt) begin
            rght_raw <= res;
            state    <= S_UPDATE;
          end else if (tmo_cnt == TMO_LAST) begin
            fault     <= 1'b1;
            en_fusion <= 1'b0;
            IR_en     <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_UPDATE: begin
          lft_IR    <= lft_raw;
          rght_IR   <= rght_raw;
          lft_opn   <= opn_next(lft_raw, lft_opn);
          rght_opn  <= opn_next(rght_raw, rght_opn);
          IR_vld    <= 1'b1;
          en_fusion <= 1'b1;
          fault     <= 1'b0;
          IR_en     <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ir_sequencer.md
IR_SEQUENCER -- requirements
Module: ir_sequencer

Interface
REQ-001 Parameter PERIOD, default 1024: clk cycles between measurement starts.
REQ-002 Parameter SETTLE, default 64: cycles IR_en is held high before the first conversion.
REQ-003 Parameter TIMEOUT, default 256: maximum cycles to wait for cnv_cmplt.
REQ-004 Parameter LFT_CHNL, default 3'd0; RGHT_CHNL, default 3'd4: A2D channel numbers.
REQ-005 Parameter OPN_THRES, default 12'h200; HYST, default 12'h040: opening-detect threshold and hysteresis.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  measurement enable; low stops new cycles.
REQ-009 strt_cnv  out  1  one-cycle A2D conversion request.
REQ-010 chnnl  out  3  A2D channel select, valid while converting.
REQ-011 cnv_cmplt  in  1  A2D conversion done pulse.
REQ-012 res  in  12  A2D result, valid when cnv_cmplt=1.
REQ-013 IR_en  out  1  IR emitter enable.
REQ-014 lft_IR, rght_IR  out  12 each  latched readings for the fusion datapath.
REQ-015 lft_opn, rght_opn  out  1 each  opening flags, with hysteresis.
REQ-016 en_fusion  out  1  fusion enable for the heading-adjust datapath.
REQ-017 IR_vld  out  1  one-cycle pulse when a new reading pair is published.
REQ-018 fault  out  1  sticky conversion-timeout flag.

Function
REQ-019 Period counter counts 0..PERIOD-1 while enable=1, wraps to 0, and is held at 0 while enable=0.
REQ-020 FSM states: IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, UPDATE.
REQ-021 IDLE->SETTLE when enable=1 and period counter==0; IR_en goes high on entry to SETTLE.
REQ-022 SETTLE lasts exactly SETTLE cycles, then ->CNV_L.
REQ-023 CNV_L: strt_cnv=1 for one cycle with chnnl=LFT_CHNL, then ->WAIT_L; chnnl holds LFT_CHNL through WAIT_L.
REQ-024 WAIT_L: on cnv_cmplt, latch res into an internal left register, then ->CNV_R (same handshake with RGHT_CHNL, then WAIT_R).
REQ-025 WAIT_R: on cnv_cmplt, latch res into an internal right register, then ->UPDATE.
REQ-026 UPDATE (1 cycle): copy both internal registers to lft_IR/rght_IR, update the opening flags, pulse IR_vld, set en_fusion=1, drop IR_en, then ->IDLE.
REQ-027 lft_IR/rght_IR change only in UPDATE, so the two readings always come from the same measurement cycle.
REQ-028 Hysteresis, per side: flag sets when reading < OPN_THRES, clears when reading > OPN_THRES+HYST, and holds otherwise; compares are unsigned 12-bit.
REQ-029 Timeout: a cycle counter runs in WAIT_L/WAIT_R; reaching TIMEOUT without cnv_cmplt sets fault=1, clears en_fusion, drops IR_en, and goes ->IDLE with outputs unpublished.
REQ-030 cnv_cmplt in any state other than WAIT_L/WAIT_R is ignored.
REQ-031 cnv_cmplt in the same cycle the timeout is reached counts as completion, not timeout.
REQ-032 enable falling mid-cycle: the sequence in progress completes and publishes normally; no new cycle starts.
REQ-033 en_fusion clears when enable=0 in IDLE, and on fault.
REQ-034 fault clears only on a successful UPDATE or on rst.
REQ-035 If the period counter wraps while the FSM is not in IDLE, that start is skipped, not queued.

Reset
REQ-036 rst=1 forces IDLE with all counters 0; strt_cnv, IR_en, IR_vld, en_fusion, fault, lft_opn and rght_opn all 0; lft_IR, rght_IR and chnnl all 0.
REQ-037 rst asserted mid-sequence aborts that sequence in the same edge; no IR_vld pulse follows.

Verification
REQ-038 Nominal: enable=1, A2D model answers 10 cycles after strt_cnv with left=0x900, right=0x100 -> IR_en high 64 cycles before the first strt_cnv; IR_vld pulses once; lft_IR=0x900, rght_IR=0x100, lft_opn=0, rght_opn=1, en_fusion=1.
REQ-039 Hysteresis: right readings 0x100, 0x220, 0x250 over successive periods -> rght_opn 1, 1, 0; then 0x1F0 -> rght_opn 1.
REQ-040 Timeout: A2D never answers the right channel -> fault=1 and en_fusion=0 256 cycles after WAIT_R entry; next good cycle clears fault.
REQ-041 Reset mid-WAIT_L -> all outputs at reset values next cycle, no IR_vld; restart aligns to period counter 0.
REQ-042 Spurious cnv_cmplt during SETTLE -> ignored; published values come from the proper conversions.
REQ-043 enable dropped in WAIT_R -> cycle publishes; no further strt_cnv; en_fusion=0 once in IDLE.
